// File: rtl/dpram_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM arbiter.
package dpram_arbiter_pkg;

  localparam int RAM_AW     = 6;
  localparam int RAM_DW     = 8;
  localparam int DPRAM_NREQ = 4;

  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } port_tag_t;

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client-side request/grant/read-return bundle shared by all requesters.
interface dpram_arbiter_if
  import dpram_arbiter_pkg::*;
#(
  parameter int NREQ = DPRAM_NREQ,
  parameter int AW   = RAM_AW,
  parameter int DW   = RAM_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ*DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// Circular priority finder: first set bit of mask_i scanning from start_i upward, wrapping.
module dpram_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((32'(start_i) + gi) % N);
    end
  endgenerate

  // Walk from the farthest position back so the nearest hit to start_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[cand[k]]) begin
        valid_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter granting up to two non-conflicting clients per cycle onto RAM ports A and B.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int NREQ = DPRAM_NREQ,
  parameter int AW   = RAM_AW,
  parameter int DW   = RAM_DW
) (
  input  logic           clk,
  input  logic           rst,
  dpram_arbiter_if.slave cli,
  output logic           ram_wre_a_o,
  output logic           ram_wre_b_o,
  output logic [AW-1:0]  ram_ad_a_o,
  output logic [AW-1:0]  ram_ad_b_o,
  output logic [DW-1:0]  ram_data_a_o,
  output logic [DW-1:0]  ram_data_b_o,
  input  logic [DW-1:0]  ram_q_a_i,
  input  logic [DW-1:0]  ram_q_b_i
);

  localparam int IW = $clog2(NREQ);

  logic [AW-1:0]   addr_w  [NREQ];
  logic [DW-1:0]   wdata_w [NREQ];
  logic [DW-1:0]   rdata_w [NREQ];
  logic [DW-1:0]   rdata_q [NREQ];

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            a_vld, b_vld;
  logic [IW-1:0]   a_idx, b_idx, b_start;
  logic [NREQ-1:0] mask_b;
  logic [NREQ-1:0] gnt_w;
  logic [NREQ-1:0] hit_a, hit_b;
  port_tag_t       tag_a_q, tag_a_d, tag_b_q, tag_b_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_client
      assign addr_w[gi]  = cli.addr[gi*AW +: AW];
      assign wdata_w[gi] = cli.wdata[gi*DW +: DW];

      // Port B may not take A itself nor anything that would collide with A in the RAM.
      assign mask_b[gi] = a_vld && cli.req[gi] && (IW'(gi) != a_idx)
                          && !((addr_w[gi] == addr_w[a_idx]) && (cli.we[gi] || cli.we[a_idx]));

      assign hit_a[gi] = tag_a_q.valid && (tag_a_q.id == TAG_IDW'(gi));
      assign hit_b[gi] = tag_b_q.valid && (tag_b_q.id == TAG_IDW'(gi));

      assign rdata_w[gi] = hit_a[gi] ? ram_q_a_i :
                           hit_b[gi] ? ram_q_b_i : rdata_q[gi];
      assign cli.rdata[gi*DW +: DW] = rdata_w[gi];
    end
  endgenerate

  assign cli.rvalid = hit_a | hit_b;
  assign cli.gnt    = gnt_w;

  dpram_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .mask_i  (cli.req),
    .start_i (ptr_q),
    .valid_o (a_vld),
    .idx_o   (a_idx)
  );

  assign b_start = IW'((32'(a_idx) + 1) % NREQ);

  dpram_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .mask_i  (mask_b),
    .start_i (b_start),
    .valid_o (b_vld),
    .idx_o   (b_idx)
  );

  always_comb begin
    gnt_w = '0;
    if (!rst) begin
      if (a_vld) gnt_w[a_idx] = 1'b1;
      if (b_vld) gnt_w[b_idx] = 1'b1;
    end
  end

  always_comb begin
    ram_wre_a_o  = !rst && a_vld && cli.we[a_idx];
    ram_ad_a_o   = a_vld ? addr_w[a_idx] : '0;
    ram_data_a_o = (a_vld && cli.we[a_idx]) ? wdata_w[a_idx] : '0;
    ram_wre_b_o  = !rst && b_vld && cli.we[b_idx];
    ram_ad_b_o   = b_vld ? addr_w[b_idx] : '0;
    ram_data_b_o = (b_vld && cli.we[b_idx]) ? wdata_w[b_idx] : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (b_vld)      ptr_d = IW'((32'(b_idx) + 1) % NREQ);
    else if (a_vld) ptr_d = IW'((32'(a_idx) + 1) % NREQ);

    tag_a_d.valid = a_vld && !cli.we[a_idx];
    tag_a_d.id    = TAG_IDW'(a_idx);
    tag_b_d.valid = b_vld && !cli.we[b_idx];
    tag_b_d.id    = TAG_IDW'(b_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      tag_a_q <= '0;
      tag_b_q <= '0;
      for (int i = 0; i < NREQ; i++) rdata_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
      for (int i = 0; i < NREQ; i++) begin
        if (hit_a[i])      rdata_q[i] <= ram_q_a_i;
        else if (hit_b[i]) rdata_q[i] <= ram_q_b_i;
      end
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural dual-port RAM and a read-return scoreboard.
module tb_dpram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ram_wre_a, ram_wre_b;
  logic [5:0] ram_ad_a, ram_ad_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic [7:0] ram_q_a, ram_q_b;
  logic [7:0] mem [64];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rexp_t;

  rexp_t      exp_q [4][$];
  logic [7:0] last_rd [4];

  dpram_arbiter_if #(.NREQ(4), .AW(6), .DW(8)) cli ();

  dpram_arbiter #(.NREQ(4), .AW(6), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cli          (cli),
    .ram_wre_a_o  (ram_wre_a),
    .ram_wre_b_o  (ram_wre_b),
    .ram_ad_a_o   (ram_ad_a),
    .ram_ad_b_o   (ram_ad_b),
    .ram_data_a_o (ram_data_a),
    .ram_data_b_o (ram_data_b),
    .ram_q_a_i    (ram_q_a),
    .ram_q_b_i    (ram_q_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM, read-before-write on each port.
  always @(posedge clk) begin
    if (ram_wre_a) mem[ram_ad_a] <= ram_data_a;
    if (ram_wre_b) mem[ram_ad_b] <= ram_data_b;
    ram_q_a <= mem[ram_ad_a];
    ram_q_b <= mem[ram_ad_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [3:0] w,
                       input logic [23:0] a, input logic [31:0] d,
                       input logic [3:0] eg, input logic ewa, input logic ewb,
                       input logic [5:0] ada, input logic [5:0] adb,
                       input logic [31:0] erd, input bit push);
    rexp_t e;
    @(posedge clk); #1;
    cli.req = r; cli.we = w; cli.addr = a; cli.wdata = d;
    @(negedge clk);
    $display("txn cyc=%0d req=%b we=%b gnt=%b wre=%b%b ad_a=%0d ad_b=%0d",
             cyc, r, w, cli.gnt, ram_wre_a, ram_wre_b, ram_ad_a, ram_ad_b);
    chk("gnt", 32'(cli.gnt), 32'(eg));
    chk("wre_a", 32'(ram_wre_a), 32'(ewa));
    chk("wre_b", 32'(ram_wre_b), 32'(ewb));
    chk("ad_a", 32'(ram_ad_a), 32'(ada));
    chk("ad_b", 32'(ram_ad_b), 32'(adb));
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i] && !w[i]) begin
          e.cyc  = cyc + 1;
          e.data = erd[i*8 +: 8];
          exp_q[i].push_back(e);
        end
      end
    end
  endtask

  // Read-return monitor.
  initial begin
    rexp_t e;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          chk("rvalid_rst", 32'(cli.rvalid[i]), 32'd0);
          chk("rdata_rst", 32'(cli.rdata[i*8 +: 8]), 32'd0);
          last_rd[i] = 8'h00;
        end else if (cli.rvalid[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid: req%0d got rdata %0h want no response", i, cli.rdata[i*8 +: 8]);
          end else begin
            e = exp_q[i].pop_front();
            $display("rsp cyc=%0d req%0d rdata=%0h", cyc, i, cli.rdata[i*8 +: 8]);
            chk("rdata", 32'(cli.rdata[i*8 +: 8]), 32'(e.data));
            chk("rlat", 32'(cyc), 32'(e.cyc));
            last_rd[i] = e.data;
          end
        end else begin
          chk("rdata_hold", 32'(cli.rdata[i*8 +: 8]), 32'(last_rd[i]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cli.req = 4'b1111; cli.we = 4'b1111; cli.addr = '0; cli.wdata = '1;
    repeat (2) begin
      @(negedge clk);
      chk("gnt_in_rst", 32'(cli.gnt), 32'd0);
      chk("wre_a_in_rst", 32'(ram_wre_a), 32'd0);
      chk("wre_b_in_rst", 32'(ram_wre_b), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cli.req = '0; cli.we = '0;

    // Preload: addr1=11, addr2=22 (dual write), addr9=99.
    apply(4'b0011, 4'b0011, {6'd0, 6'd0, 6'd2, 6'd1}, {8'h00, 8'h00, 8'h22, 8'h11},
          4'b0011, 1'b1, 1'b1, 6'd1, 6'd2, 32'h0, 1'b1);
    apply(4'b0100, 4'b0100, {6'd0, 6'd9, 6'd0, 6'd0}, {8'h00, 8'h99, 8'h00, 8'h00},
          4'b0100, 1'b1, 1'b0, 6'd9, 6'd0, 32'h0, 1'b1);

    // Read at addr 5 granted, then reset lands before its return: no response expected.
    apply(4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd5}, 32'h0,
          4'b0001, 1'b0, 1'b0, 6'd5, 6'd0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    cli.req = 4'b0011; cli.we = 4'b0010; cli.addr = {6'd0, 6'd0, 6'd6, 6'd5};
    @(negedge clk);
    chk("gnt_mid_rst", 32'(cli.gnt), 32'd0);
    chk("wre_a_mid_rst", 32'(ram_wre_a), 32'd0);
    chk("wre_b_mid_rst", 32'(ram_wre_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cli.req = '0; cli.we = '0;

    // Three readers right after reset: ptr=0 gives {0,1}.
    apply(4'b0111, 4'b0000, {6'd0, 6'd9, 6'd2, 6'd1}, 32'h0,
          4'b0011, 1'b0, 1'b0, 6'd1, 6'd2, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b1);
    apply(4'b0100, 4'b0000, {6'd0, 6'd9, 6'd0, 6'd0}, 32'h0,
          4'b0100, 1'b0, 1'b0, 6'd9, 6'd0, {8'h00, 8'h99, 8'h00, 8'h00}, 1'b1);
    // Single writer then reader on addr 3.
    apply(4'b0001, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd3}, {8'h00, 8'h00, 8'h00, 8'hA5},
          4'b0001, 1'b1, 1'b0, 6'd3, 6'd0, 32'h0, 1'b1);
    apply(4'b0010, 4'b0000, {6'd0, 6'd0, 6'd3, 6'd0}, 32'h0,
          4'b0010, 1'b0, 1'b0, 6'd3, 6'd0, {8'h00, 8'h00, 8'hA5, 8'h00}, 1'b1);
    apply(4'b1000, 4'b0000, {6'd9, 6'd0, 6'd0, 6'd0}, 32'h0,
          4'b1000, 1'b0, 1'b0, 6'd9, 6'd0, {8'h99, 8'h00, 8'h00, 8'h00}, 1'b1);
    // Dual read grant from ptr=0: req0 on A, req2 on B.
    apply(4'b0101, 4'b0000, {6'd0, 6'd2, 6'd0, 6'd1}, 32'h0,
          4'b0101, 1'b0, 1'b0, 6'd1, 6'd2, {8'h00, 8'h22, 8'h00, 8'h11}, 1'b1);
    apply(4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd3}, 32'h0,
          4'b0001, 1'b0, 1'b0, 6'd3, 6'd0, {8'h00, 8'h00, 8'h00, 8'hA5}, 1'b1);
    // Conflict from ptr=1: req2 skipped, req3 on B; req2 then sees the new data.
    apply(4'b1110, 4'b0010, {6'd9, 6'd7, 6'd7, 6'd0}, {8'h00, 8'h00, 8'h5C, 8'h00},
          4'b1010, 1'b1, 1'b0, 6'd7, 6'd9, {8'h99, 8'h00, 8'h00, 8'h00}, 1'b1);
    apply(4'b0100, 4'b0000, {6'd0, 6'd7, 6'd0, 6'd0}, 32'h0,
          4'b0100, 1'b0, 1'b0, 6'd7, 6'd0, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b1);
    apply(4'b1000, 4'b1000, {6'd4, 6'd0, 6'd0, 6'd0}, {8'h44, 8'h00, 8'h00, 8'h00},
          4'b1000, 1'b1, 1'b0, 6'd4, 6'd0, 32'h0, 1'b1);
    // Fairness: all four reading, grants alternate {0,1},{2,3}.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        apply(4'b1111, 4'b0000, {6'd7, 6'd3, 6'd2, 6'd1}, 32'h0,
              4'b0011, 1'b0, 1'b0, 6'd1, 6'd2, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b1);
      else
        apply(4'b1111, 4'b0000, {6'd7, 6'd3, 6'd2, 6'd1}, 32'h0,
              4'b1100, 1'b0, 1'b0, 6'd3, 6'd7, {8'h5C, 8'hA5, 8'h00, 8'h00}, 1'b1);
    end
    // Idle, then ptr still 0.
    apply(4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 1'b1);
    apply(4'b0111, 4'b0000, {6'd0, 6'd3, 6'd2, 6'd1}, 32'h0,
          4'b0011, 1'b0, 1'b0, 6'd1, 6'd2, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b1);
    // Same-address reads never conflict.
    apply(4'b1100, 4'b0000, {6'd4, 6'd4, 6'd0, 6'd0}, 32'h0,
          4'b1100, 1'b0, 1'b0, 6'd4, 6'd4, {8'h44, 8'h44, 8'h00, 8'h00}, 1'b1);
    apply(4'b0000, 4'b0000, 24'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 1'b1);

    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < 4; i++) chk("drain", 32'(exp_q[i].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
